knight_rider_gen: RTL and testbench

- Sequential pattern generator for the ALU's knight-rider operation (select code 4'b1100).
- Drives the 8-bit nightrid input of the ALU output multiplexer, directly upstream of it.
- A lit segment sweeps between bit 0 and bit WIDTH-1 at a selectable step rate.
- Three display modes: single, tail, fill.

---
 rtl/knight_rider_gen_pkg.sv | 24 ++
 rtl/knight_rider_gen_if.sv | 33 +++
 rtl/knight_rider_gen_prescaler.sv | 48 ++++
 rtl/knight_rider_gen.sv | 173 +++++++++++++++++
 tb/tb_knight_rider_gen.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/knight_rider_gen_pkg.sv
// knight_rider_pkg
// Shared definitions for the knight-rider pattern generator:
//   - state_e      : sweep FSM states (explicit encodings kept stable for
//                    anyone decoding the state from a waveform or debug bus)
//   - MODE_*       : display mode codes carried on the mode input
//   - step_period  : clocks per position step for a given base divider/speed
package knight_rider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_TAIL   = 2'b01;
  localparam logic [1:0] MODE_FILL   = 2'b10;

  // speed 3 is the fastest (base_div clocks); each lower speed doubles it.
  function automatic int unsigned step_period(int unsigned base_div, logic [1:0] speed);
    return base_div << (2'd3 - speed);
  endfunction

endpackage

// File: rtl/knight_rider_gen_if.sv
// knight_rider_gen_if
// Control and display bundle between the ALU sequencer and the generator.
//   en, hold     : run enable / freeze request        (master -> slave)
//   speed, mode  : step rate select / display mode     (master -> slave)
//   pattern      : WIDTH-bit display word for the mux  (slave -> master)
//   pos, dir     : lead position and sweep direction   (slave -> master)
//   tick, bounce : step and reversal pulses            (slave -> master)
interface knight_rider_gen_if #(
  parameter int WIDTH = 8
);
  localparam int PW = $clog2(WIDTH);

  logic             en;
  logic             hold;
  logic [1:0]       speed;
  logic [1:0]       mode;
  logic [WIDTH-1:0] pattern;
  logic [PW-1:0]    pos;
  logic             dir;
  logic             tick;
  logic             bounce;

  modport master (
    output en, hold, speed, mode,
    input  pattern, pos, dir, tick, bounce
  );

  modport slave (
    input  en, hold, speed, mode,
    output pattern, pos, dir, tick, bounce
  );

endinterface

// File: rtl/knight_rider_gen_prescaler.sv
// kr_prescaler
// Step-rate prescaler. Counts clocks while run is high and raises step in
// the cycle where the count reaches the terminal value for the current speed.
//   clk, rst : system clock, async active-high reset
//   run      : count enable (generator sweeping and not held)
//   clear    : force count back to zero (generator idle / disabled)
//   speed    : selects period BASE_DIV * 2^(3-speed)
//   step     : combinational strobe, high when this edge should move pos
module kr_prescaler
  import knight_rider_pkg::*;
#(
  parameter int BASE_DIV = 4,
  parameter int DIV_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       step
);

  logic [DIV_BITS-1:0] cnt;
  logic [DIV_BITS-1:0] term;

  assign term = DIV_BITS'(step_period(BASE_DIV, speed) - 1);

  // >= rather than == so that switching to a faster speed while the count
  // is already past the new terminal value steps on the very next edge.
  assign step = run & (cnt >= term);

  // Count is frozen whenever run is low, so a hold resumes the interval
  // where it left off instead of starting a fresh period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt >= term) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/knight_rider_gen.sv
// knight_rider_gen
// Knight-rider pattern generator feeding the ALU output mux nightrid input
// (select code 4'b1100). A lit segment sweeps between bit 0 and bit WIDTH-1
// with no dwell at the ends, in single, tail or fill display modes.
//   clk, rst : system clock, async active-high reset
//   bus      : knight_rider_gen_if slave modport (en, hold, speed, mode in;
//              pattern, pos, dir, tick, bounce out, all registered)
module knight_rider_gen
  import knight_rider_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int BASE_DIV = 4,
  parameter int DIV_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  knight_rider_gen_if.slave   bus
);

  localparam int            PW      = $clog2(WIDTH);
  localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             nbr_off_q, nbr_off_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic             tick_q;
  logic             bounce_q, bounce_d;
  logic             run;
  logic             clear;
  logic             step;

  assign run   = bus.en & ~bus.hold & (state_q != IDLE);
  assign clear = ~bus.en | (state_q == IDLE);

  kr_prescaler #(
    .BASE_DIV (BASE_DIV),
    .DIV_BITS (DIV_BITS)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (clear),
    .speed (bus.speed),
    .step  (step)
  );

  // Display word for a given lead position. no_nbr suppresses the tail
  // segment for the first position after a reversal, where the trailing
  // neighbour would otherwise light the end bit just left.
  function automatic logic [WIDTH-1:0] encode(logic [PW-1:0] p, logic d,
                                              logic [1:0] m, logic no_nbr);
    logic [WIDTH-1:0] r;
    r = '0;
    case (m)
      MODE_FILL: begin
        for (int i = 0; i < WIDTH; i++) begin
          r[i] = (PW'(i) <= p);
        end
      end
      MODE_TAIL: begin
        r[p] = 1'b1;
        if (!no_nbr) begin
          if (d && (p != '0)) begin
            r[p - 1'b1] = 1'b1;
          end else if (!d && (p != POS_MAX)) begin
            r[p + 1'b1] = 1'b1;
          end
        end
      end
      default: r[p] = 1'b1;
    endcase
    return r;
  endfunction

  // Next-state sweep logic. en low always wins and returns everything to
  // reset values; pos/dir only move on a prescaler step, which cannot occur
  // while held.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    nbr_off_d = nbr_off_q;
    bounce_d  = 1'b0;
    if (!bus.en) begin
      state_d   = IDLE;
      pos_d     = '0;
      dir_d     = 1'b1;
      nbr_off_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = UP;
          pos_d     = '0;
          dir_d     = 1'b1;
          nbr_off_d = 1'b0;
        end
        UP: begin
          if (step) begin
            nbr_off_d = 1'b0;
            if (pos_q == POS_MAX) begin
              pos_d     = POS_MAX - 1'b1;
              dir_d     = 1'b0;
              state_d   = DOWN;
              bounce_d  = 1'b1;
              nbr_off_d = 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end
        end
        DOWN: begin
          if (step) begin
            nbr_off_d = 1'b0;
            if (pos_q == '0) begin
              pos_d     = PW'(1);
              dir_d     = 1'b1;
              state_d   = UP;
              bounce_d  = 1'b1;
              nbr_off_d = 1'b1;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          pos_d     = '0;
          dir_d     = 1'b1;
          nbr_off_d = 1'b0;
        end
      endcase
    end
  end

  // Pattern is built from the next-state position so it lines up with pos
  // and dir on the same edge; it still tracks mode while held.
  always_comb begin
    pattern_d = '0;
    if (bus.en) begin
      pattern_d = encode(pos_d, dir_d, bus.mode, nbr_off_d);
    end
  end

  // All outputs registered together so the mux sees one coherent update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      dir_q     <= 1'b1;
      nbr_off_q <= 1'b0;
      pattern_q <= '0;
      tick_q    <= 1'b0;
      bounce_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      nbr_off_q <= nbr_off_d;
      pattern_q <= pattern_d;
      tick_q    <= step;
      bounce_q  <= bounce_d;
    end
  end

  assign bus.pattern = pattern_q;
  assign bus.pos     = pos_q;
  assign bus.dir     = dir_q;
  assign bus.tick    = tick_q;
  assign bus.bounce  = bounce_q;

endmodule

// File: tb/tb_knight_rider_gen.sv
// tb_knight_rider_gen
// Self-checking bench for knight_rider_gen with WIDTH=8, BASE_DIV=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_knight_rider_gen;
  import knight_rider_pkg::*;

  typedef struct {
    string      name;
    logic       en;
    logic       hold;
    logic [1:0] speed;
    logic [1:0] mode;
    int         ncyc;
    logic [7:0] pattern;
    logic [2:0] pos;
    logic       dir;
    logic       tick;
    logic       bounce;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];

  knight_rider_gen_if #(.WIDTH(8)) bus ();

  knight_rider_gen #(
    .WIDTH    (8),
    .BASE_DIV (4),
    .DIV_BITS (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input string name, input logic en, input logic hold,
                        input logic [1:0] speed, input logic [1:0] mode,
                        input int ncyc, input logic [7:0] pattern,
                        input logic [2:0] pos, input logic dir,
                        input logic tick, input logic bounce);
    vec_t v;
    v.name = name; v.en = en; v.hold = hold; v.speed = speed; v.mode = mode;
    v.ncyc = ncyc; v.pattern = pattern; v.pos = pos; v.dir = dir;
    v.tick = tick; v.bounce = bounce;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic en, input logic hold,
                               input logic [1:0] speed, input logic [1:0] mode,
                               input int ncyc);
    bus.en    = en;
    bus.hold  = hold;
    bus.speed = speed;
    bus.mode  = mode;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] pattern,
                             input logic [2:0] pos, input logic dir,
                             input logic tick, input logic bounce);
    checks++;
    if (bus.pattern !== pattern || bus.pos !== pos || bus.dir !== dir ||
        bus.tick !== tick || bus.bounce !== bounce) begin
      errors++;
      $display("[TB] FAIL %s: got pattern=%h pos=%0d dir=%b tick=%b bounce=%b, want pattern=%h pos=%0d dir=%b tick=%b bounce=%b",
               name, bus.pattern, bus.pos, bus.dir, bus.tick, bus.bounce,
               pattern, pos, dir, tick, bounce);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.hold  = 1'b0;
    bus.speed = 2'd3;
    bus.mode  = MODE_SINGLE;

    //          name            en hold spd mode ncyc  pat    pos dir tk bn
    addVec("start",           1, 0, 3, 0,  1, 8'h01, 0, 1, 0, 0);
    addVec("wait_first",      1, 0, 3, 0,  3, 8'h01, 0, 1, 0, 0);
    addVec("first_step",      1, 0, 3, 0,  1, 8'h02, 1, 1, 1, 0);
    addVec("tick_clear",      1, 0, 3, 0,  1, 8'h02, 1, 1, 0, 0);
    addVec("reach_top",       1, 0, 3, 0, 23, 8'h80, 7, 1, 1, 0);
    addVec("bounce_top",      1, 0, 3, 0,  4, 8'h40, 6, 0, 1, 1);
    addVec("bounce_clear",    1, 0, 3, 0,  1, 8'h40, 6, 0, 0, 0);
    addVec("reach_bottom",    1, 0, 3, 0, 23, 8'h01, 0, 0, 1, 0);
    addVec("bounce_bottom",   1, 0, 3, 0,  4, 8'h02, 1, 1, 1, 1);
    addVec("tail_after_bnc",  1, 0, 3, 1,  1, 8'h02, 1, 1, 0, 0);
    addVec("tail_pos2",       1, 0, 3, 1,  3, 8'h06, 2, 1, 1, 0);
    addVec("tail_pos3",       1, 0, 3, 1,  4, 8'h0C, 3, 1, 1, 0);
    addVec("tail_pos7",       1, 0, 3, 1, 16, 8'hC0, 7, 1, 1, 0);
    addVec("tail_bounce",     1, 0, 3, 1,  4, 8'h40, 6, 0, 1, 1);
    addVec("tail_down5",      1, 0, 3, 1,  4, 8'h60, 5, 0, 1, 0);
    addVec("fill_pos5",       1, 0, 3, 2,  1, 8'h3F, 5, 0, 0, 0);
    addVec("fill_pos4",       1, 0, 3, 2,  3, 8'h1F, 4, 0, 1, 0);
    addVec("fill_pos0",       1, 0, 3, 2, 16, 8'h01, 0, 0, 1, 0);
    addVec("fill_bounce",     1, 0, 3, 2,  4, 8'h03, 1, 1, 1, 1);
    addVec("mode11_single",   1, 0, 3, 3,  1, 8'h02, 1, 1, 0, 0);
    addVec("pre_hold_step",   1, 0, 3, 0,  3, 8'h04, 2, 1, 1, 0);
    addVec("pre_hold_cnt2",   1, 0, 3, 0,  2, 8'h04, 2, 1, 0, 0);
    addVec("hold_20",         1, 1, 3, 0, 20, 8'h04, 2, 1, 0, 0);
    addVec("hold_mode_fill",  1, 1, 3, 2,  1, 8'h07, 2, 1, 0, 0);
    addVec("release_cnt3",    1, 0, 3, 0,  1, 8'h04, 2, 1, 0, 0);
    addVec("release_step",    1, 0, 3, 0,  1, 8'h08, 3, 1, 1, 0);
    addVec("hold_again",      1, 1, 3, 0,  1, 8'h08, 3, 1, 0, 0);
    addVec("en_off_in_hold",  0, 1, 3, 0,  1, 8'h00, 0, 1, 0, 0);
    addVec("idle_stays",      0, 0, 3, 0,  3, 8'h00, 0, 1, 0, 0);

    repeat (2) @(negedge clk);
    checkOutput("reset_state", 8'h00, 0, 1, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_rst", 8'h00, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].hold, vecs[i].speed, vecs[i].mode, vecs[i].ncyc);
      checkOutput(vecs[i].name, vecs[i].pattern, vecs[i].pos, vecs[i].dir,
                  vecs[i].tick, vecs[i].bounce);
    end

    // Slowest speed: 32 clocks per step, then a speed-up with the count
    // already beyond the new terminal value steps on the next edge.
    applyStimulus(1, 0, 0, MODE_SINGLE, 1);
    checkOutput("slow_start", 8'h01, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, MODE_SINGLE, 31);
    checkOutput("slow_no_step", 8'h01, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, MODE_SINGLE, 1);
    checkOutput("slow_step32", 8'h02, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, MODE_SINGLE, 10);
    checkOutput("slow_cnt10", 8'h02, 1, 1, 0, 0);
    applyStimulus(1, 0, 3, MODE_SINGLE, 1);
    checkOutput("speedup_now", 8'h04, 2, 1, 1, 0);
    applyStimulus(1, 0, 3, MODE_SINGLE, 3);
    checkOutput("speedup_gap", 8'h04, 2, 1, 0, 0);
    applyStimulus(1, 0, 3, MODE_SINGLE, 1);
    checkOutput("speedup_next", 8'h08, 3, 1, 1, 0);

    // Reach pos 6 moving down, then reset asynchronously between edges.
    applyStimulus(1, 0, 3, MODE_SINGLE, 20);
    checkOutput("pre_rst_bounce", 8'h40, 6, 0, 1, 1);
    applyStimulus(1, 0, 3, MODE_SINGLE, 1);
    checkOutput("pre_rst_pos6", 8'h40, 6, 0, 0, 0);
    #1 rst = 1'b1;
    #1 checkOutput("async_rst", 8'h00, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("restart", 8'h01, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
